// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the CPU sequencer: control word, schedule, flags, condition codes.
// Also holds the sequencer state enum and the fixed FETCH/NOP control words.
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {SEQ_FETCH, SEQ_EXEC, SEQ_SKIP} seq_state_t;

    typedef enum logic [1:0] {COND_NZ, COND_Z, COND_NC, COND_C} condition_code_t;
    typedef enum logic [1:0] {ADDR_PC, ADDR_SP, ADDR_HL, ADDR_WZ} addr_src_t;
    typedef enum logic [1:0] {IDU_NOP, IDU_INC, IDU_DEC, IDU_PASS} idu_op_t;
    typedef enum logic [1:0] {IDU_PC, IDU_SP, IDU_HL, IDU_WZ} idu_reg_t;

    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_NOP = 4'd0;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef struct packed {
        logic      addr_en;
        addr_src_t addr_src;
        logic      data_wr;
        logic      ir_wren;
        logic      reg_wren;
        logic [2:0] reg_sel;
        idu_op_t   idu_op;
        idu_reg_t  idu_src;
        idu_reg_t  idu_dst;
        logic      idu_wren;
        alu_op_t   alu_op;
        logic      cc_check;
    } control_signals_t;

    localparam int MAX_M_CYCLES = 6;

    typedef struct packed {
        logic [2:0]                                m_cycles;
        control_signals_t [MAX_M_CYCLES-1:0]       instruction_controls;
        condition_code_t                           condition;
        logic                                      cb_prefix_next;
        logic                                      bit_cmd;
    } schedule_t;

    localparam control_signals_t FETCH_CTRL = '{
        addr_en:  1'b1,
        addr_src: ADDR_PC,
        data_wr:  1'b0,
        ir_wren:  1'b1,
        reg_wren: 1'b0,
        reg_sel:  3'd0,
        idu_op:   IDU_INC,
        idu_src:  IDU_PC,
        idu_dst:  IDU_PC,
        idu_wren: 1'b1,
        alu_op:   ALU_NOP,
        cc_check: 1'b0
    };

    localparam control_signals_t NOP_CTRL = '0;

    // Schedules encode 0..7 m-cycles; only 1..6 are meaningful.
    function automatic logic [2:0] eff_len(input logic [2:0] m);
        if (m == 3'd0)
            return 3'd1;
        else if (m == 3'd7)
            return 3'd6;
        else
            return m;
    endfunction

endpackage

// File: rtl/gb_cpu_cond_eval.sv
// Evaluates a branch condition code against the current F-register flags.
module gb_cpu_cond_eval
    import gb_cpu_common_pkg::*;
(
    input  condition_code_t cond_i,
    input  alu_flags_t      flags_i,
    output logic            met_o
);

    logic unused_flags;
    assign unused_flags = ^{flags_i.n, flags_i.h};

    always_comb begin
        met_o = 1'b0;
        case (cond_i)
            COND_NZ: met_o = ~flags_i.z;
            COND_Z:  met_o =  flags_i.z;
            COND_NC: met_o = ~flags_i.c;
            COND_C:  met_o =  flags_i.c;
            default: met_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gb_cpu_schedule_sequencer.sv
// Steps through the m-cycles of a latched instruction schedule, handling
// conditional early exit, stalls, CB-prefix chaining and interrupt dispatch.
module gb_cpu_schedule_sequencer
    import gb_cpu_common_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  schedule_t        sched_i,
    input  schedule_t        int_sched_i,
    input  logic             int_pending_i,
    input  alu_flags_t       flags_i,
    input  logic             stall_i,
    output control_signals_t ctrl_o,
    output logic [2:0]       m_cycle_o,
    output logic             boundary_o,
    output logic             cb_mode_o,
    output logic             bit_cmd_o,
    output logic             int_ack_o
);

    seq_state_t       state_q;
    logic [2:0]       count_q;
    schedule_t        sched_q;
    logic             int_ack_q;

    control_signals_t ctrl_raw;
    logic [2:0]       mc_raw;
    logic             bnd_raw;
    logic [2:0]       last;
    logic             cond_met;
    logic             take_int;
    logic             skip;

    gb_cpu_cond_eval u_cond_eval (
        .cond_i  (sched_q.condition),
        .flags_i (flags_i),
        .met_o   (cond_met)
    );

    always_comb begin
        last     = eff_len(sched_q.m_cycles) - 3'd1;
        ctrl_raw = FETCH_CTRL;
        mc_raw   = 3'd0;
        bnd_raw  = 1'b1;
        case (state_q)
            SEQ_EXEC: begin
                ctrl_raw = sched_q.instruction_controls[count_q];
                mc_raw   = count_q;
                bnd_raw  = (count_q == last);
            end
            SEQ_SKIP: begin
                ctrl_raw = sched_q.instruction_controls[last];
                mc_raw   = last;
                bnd_raw  = 1'b1;
            end
            default: begin
                ctrl_raw = FETCH_CTRL;
                mc_raw   = 3'd0;
                bnd_raw  = 1'b1;
            end
        endcase
        // A CB prefix and its operand byte must stay glued together.
        take_int = int_pending_i & ~sched_q.cb_prefix_next;
        skip     = ctrl_raw.cc_check & ~cond_met;
    end

    assign ctrl_o     = stall_i ? NOP_CTRL : ctrl_raw;
    assign boundary_o = bnd_raw & ~stall_i;
    assign int_ack_o  = int_ack_q & ~stall_i;
    assign m_cycle_o  = mc_raw;
    assign cb_mode_o  = sched_q.cb_prefix_next;
    assign bit_cmd_o  = sched_q.bit_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_FETCH;
            count_q   <= 3'd0;
            sched_q   <= '0;
            int_ack_q <= 1'b0;
        end else if (!stall_i) begin
            int_ack_q <= 1'b0;
            if (bnd_raw) begin
                sched_q   <= take_int ? int_sched_i : sched_i;
                int_ack_q <= take_int;
                count_q   <= 3'd0;
                state_q   <= SEQ_EXEC;
            end else if (state_q == SEQ_EXEC) begin
                // cc_check on the last entry never gets here: boundary wins.
                if (skip) begin
                    state_q <= SEQ_SKIP;
                    count_q <= last;
                end else begin
                    count_q <= count_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_cpu_schedule_sequencer.sv
// Directed bench for the schedule sequencer: fetch, conditional skip, CB/interrupt
// interplay, stalls, length clamping and asynchronous reset.
module tb_gb_cpu_schedule_sequencer;
    import gb_cpu_common_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    schedule_t        sched_i;
    schedule_t        int_sched_i;
    logic             int_pending_i;
    alu_flags_t       flags_i;
    logic             stall_i;
    control_signals_t ctrl_o;
    logic [2:0]       m_cycle_o;
    logic             boundary_o;
    logic             cb_mode_o;
    logic             bit_cmd_o;
    logic             int_ack_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gb_cpu_schedule_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sched_i       (sched_i),
        .int_sched_i   (int_sched_i),
        .int_pending_i (int_pending_i),
        .flags_i       (flags_i),
        .stall_i       (stall_i),
        .ctrl_o        (ctrl_o),
        .m_cycle_o     (m_cycle_o),
        .boundary_o    (boundary_o),
        .cb_mode_o     (cb_mode_o),
        .bit_cmd_o     (bit_cmd_o),
        .int_ack_o     (int_ack_o)
    );

    function automatic control_signals_t ent(input logic [2:0] tag, input int k, input logic cc);
        control_signals_t c;
        c          = '0;
        c.reg_wren = 1'b1;
        c.reg_sel  = tag;
        c.alu_op   = alu_op_t'(k + 1);
        c.cc_check = cc;
        return c;
    endfunction

    function automatic schedule_t mk(input logic [2:0] tag, input logic [2:0] m, input int cc_idx,
                                     input condition_code_t cond, input logic cbn, input logic bc);
        schedule_t s;
        s = '0;
        s.m_cycles = m;
        for (int k = 0; k < 6; k++) s.instruction_controls[k] = ent(tag, k, k == cc_idx);
        s.condition      = cond;
        s.cb_prefix_next = cbn;
        s.bit_cmd        = bc;
        return s;
    endfunction

    function automatic control_signals_t fetch_exp();
        control_signals_t f;
        f          = '0;
        f.addr_en  = 1'b1;
        f.addr_src = ADDR_PC;
        f.ir_wren  = 1'b1;
        f.idu_op   = IDU_INC;
        f.idu_src  = IDU_PC;
        f.idu_dst  = IDU_PC;
        f.idu_wren = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one m-cycle's outputs, then advance to just after the next edge.
    task automatic cyc(input string tag, input control_signals_t ec, input logic [2:0] em, input logic eb);
        #1;
        chk({tag, ".ctrl"}, 32'(ctrl_o), 32'(ec));
        chk({tag, ".mc"}, 32'(m_cycle_o), 32'(em));
        chk({tag, ".bnd"}, 32'(boundary_o), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    schedule_t s3, jra, jr0, cbp, cbo, isr, s4, l0, s7, s5;

    initial begin
        s3  = mk(3'd1, 3'd3, -1, COND_NZ, 1'b0, 1'b0);
        jra = mk(3'd2, 3'd3,  1, COND_NZ, 1'b0, 1'b0);
        jr0 = mk(3'd3, 3'd3,  0, COND_C,  1'b0, 1'b0);
        cbp = mk(3'd4, 3'd1, -1, COND_NZ, 1'b1, 1'b0);
        cbo = mk(3'd5, 3'd2, -1, COND_NZ, 1'b0, 1'b1);
        isr = mk(3'd6, 3'd2, -1, COND_NZ, 1'b0, 1'b0);
        s4  = mk(3'd7, 3'd4, -1, COND_NZ, 1'b0, 1'b0);
        l0  = mk(3'd0, 3'd0, -1, COND_NZ, 1'b0, 1'b0);
        s7  = mk(3'd2, 3'd7, -1, COND_NZ, 1'b0, 1'b0);
        s5  = mk(3'd3, 3'd5, -1, COND_NZ, 1'b0, 1'b1);

        rst_n = 1'b0; stall_i = 1'b0; int_pending_i = 1'b0; flags_i = '0;
        sched_i = s3; int_sched_i = isr;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.ctrl", 32'(ctrl_o), 32'(fetch_exp()));
        chk("rst.bnd", 32'(boundary_o), 32'd1);
        chk("rst.mc", 32'(m_cycle_o), 32'd0);
        chk("rst.cb", 32'(cb_mode_o), 32'd0);
        chk("rst.bit", 32'(bit_cmd_o), 32'd0);
        chk("rst.ack", 32'(int_ack_o), 32'd0);
        rst_n = 1'b1;

        cyc("fetch", fetch_exp(), 3'd0, 1'b1);
        cyc("s3.0", ent(1, 0, 0), 3'd0, 1'b0);
        cyc("s3.1", ent(1, 1, 0), 3'd1, 1'b0);
        sched_i = jra; flags_i.z = 1'b1;
        cyc("s3.2", ent(1, 2, 0), 3'd2, 1'b1);

        // JR NZ with Z=1: fails on entry 1, skips to entry 2
        cyc("jrf.0", ent(2, 0, 0), 3'd0, 1'b0);
        cyc("jrf.1", ent(2, 1, 1), 3'd1, 1'b0);
        flags_i.z = 1'b0;
        cyc("jrf.2", ent(2, 2, 0), 3'd2, 1'b1);

        // JR NZ with Z=0: passes, same three cycles
        cyc("jrp.0", ent(2, 0, 0), 3'd0, 1'b0);
        cyc("jrp.1", ent(2, 1, 1), 3'd1, 1'b0);
        sched_i = jr0;
        cyc("jrp.2", ent(2, 2, 0), 3'd2, 1'b1);

        // cc on entry 0, C=0 with condition C: 0 then 2
        cyc("jr0.0", ent(3, 0, 1), 3'd0, 1'b0);
        sched_i = cbp;
        cyc("jr0.2", ent(3, 2, 0), 3'd2, 1'b1);

        // CB prefix followed by operand; interrupt must wait
        chk("cb.mode", 32'(cb_mode_o), 32'd1);
        int_pending_i = 1'b1; sched_i = cbo;
        cyc("cb.0", ent(4, 0, 0), 3'd0, 1'b1);
        chk("cbo.ack", 32'(int_ack_o), 32'd0);
        chk("cbo.bit", 32'(bit_cmd_o), 32'd1);
        chk("cbo.mode", 32'(cb_mode_o), 32'd0);
        sched_i = s4;
        cyc("cbo.0", ent(5, 0, 0), 3'd0, 1'b0);
        cyc("cbo.1", ent(5, 1, 0), 3'd1, 1'b1);
        chk("isr.ack", 32'(int_ack_o), 32'd1);
        int_pending_i = 1'b0;
        cyc("isr.0", ent(6, 0, 0), 3'd0, 1'b0);
        chk("isr.ack1", 32'(int_ack_o), 32'd0);
        cyc("isr.1", ent(6, 1, 0), 3'd1, 1'b1);

        // L=4 with a two-cycle stall at m_cycle 1
        cyc("s4.0", ent(7, 0, 0), 3'd0, 1'b0);
        stall_i = 1'b1;
        cyc("stall.a", '0, 3'd1, 1'b0);
        chk("stall.ack", 32'(int_ack_o), 32'd0);
        cyc("stall.b", '0, 3'd1, 1'b0);
        stall_i = 1'b0;
        cyc("s4.1", ent(7, 1, 0), 3'd1, 1'b0);
        cyc("s4.2", ent(7, 2, 0), 3'd2, 1'b0);
        sched_i = l0;
        cyc("s4.3", ent(7, 3, 0), 3'd3, 1'b1);

        // m_cycles=0 clamps to 1: boundary every cycle
        cyc("l0.a", ent(0, 0, 0), 3'd0, 1'b1);
        sched_i = s7;
        cyc("l0.b", ent(0, 0, 0), 3'd0, 1'b1);

        // m_cycles=7 clamps to 6
        for (int k = 0; k < 6; k++) begin
            if (k == 5) sched_i = s5;
            cyc($sformatf("s7.%0d", k), ent(2, k, 0), 3'(k), k == 5);
        end

        // Reset in the middle of an L=5 instruction
        sched_i = s3;
        cyc("s5.0", ent(3, 0, 0), 3'd0, 1'b0);
        cyc("s5.1", ent(3, 1, 0), 3'd1, 1'b0);
        #1;
        chk("s5.2.ctrl", 32'(ctrl_o), 32'(ent(3, 2, 0)));
        chk("s5.2.bit", 32'(bit_cmd_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.ctrl", 32'(ctrl_o), 32'(fetch_exp()));
        chk("arst.mc", 32'(m_cycle_o), 32'd0);
        chk("arst.bnd", 32'(boundary_o), 32'd1);
        chk("arst.bit", 32'(bit_cmd_o), 32'd0);
        chk("arst.cb", 32'(cb_mode_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("refetch", fetch_exp(), 3'd0, 1'b1);
        cyc("re.s3.0", ent(1, 0, 0), 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gb_cpu_schedule_sequencer.md
GB_CPU_SCHEDULE_SEQUENCER -- requirements
Module: gb_cpu_schedule_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock; one edge per m-cycle.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sched_i  input  schedule_t  combinational decoder schedule for the current IR contents.
REQ-005 int_sched_i  input  schedule_t  interrupt-dispatch schedule.
REQ-006 int_pending_i  input  1  interrupt requested AND IME set.
REQ-007 flags_i  input  alu_flags_t  current F-register flags.
REQ-008 stall_i  input  1  freezes sequencing for this cycle.
REQ-009 ctrl_o  output  control_signals_t  control word for the current m-cycle.
REQ-010 m_cycle_o  output  3  index of the current m-cycle within the instruction.
REQ-011 boundary_o  output  1  high on the last m-cycle (IR load/overlapped fetch).
REQ-012 cb_mode_o  output  1  decoder must interpret the next IR as 0xCB-prefixed.
REQ-013 bit_cmd_o  output  1  latched bit_cmd of the active schedule.
REQ-014 int_ack_o  output  1  one-cycle pulse when an interrupt schedule is latched.

Function
REQ-015 instruction_controls[k] SHALL be driven on ctrl_o during m-cycle k (k=0 first).
REQ-016 Effective length L SHALL be m_cycles clamped to 1..6 (0->1, 7->6).
REQ-017 States: FETCH (post-reset single fetch cycle), EXEC, SKIP (condition failed).
REQ-018 In FETCH, ctrl_o SHALL be FETCH_CTRL: addr bus PC, data in->IR, IDU_INC PC->PC with idu_wren=1, ALU_NOP, every other field zero; boundary_o=1.
REQ-019 At a boundary edge not stalled, the sequencer SHALL latch the next schedule, set count=0, and enter EXEC.
REQ-020 Next schedule SHALL be int_sched_i if int_pending_i=1 and the ending schedule has cb_prefix_next=0; otherwise sched_i.
REQ-021 int_ack_o SHALL pulse for exactly the cycle after an int_sched_i latch.
REQ-022 cb_mode_o SHALL equal the cb_prefix_next of the schedule being executed; a CB prefix and its operand SHALL never be split by an interrupt.
REQ-023 In EXEC, count SHALL increment each non-stalled cycle; boundary_o=1 when count=L-1.
REQ-024 When ctrl_o.cc_check=1, the condition SHALL be evaluated against schedule.condition: NZ:!Z, Z:Z, NC:!C, C:C.
REQ-025 On a failed condition, the next cycle SHALL be SKIP, driving instruction_controls[L-1] with m_cycle_o=L-1 and boundary_o=1.
REQ-026 On a passed condition, sequencing SHALL continue normally.
REQ-027 cc_check on entry L-1 SHALL be ignored.
REQ-028 While stall_i=1, state, count and latched schedule SHALL hold, and ctrl_o SHALL be all-zero (no wren, no bus drive, IDU_NOP, ALU_NOP); boundary_o=0 and int_ack_o=0.
REQ-029 A schedule with L=1 SHALL produce boundary_o on every cycle of that instruction.

Reset
REQ-030 Reset SHALL clear to: state FETCH, count 0, latched schedule all-zero, cb_mode_o=0, bit_cmd_o=0, int_ack_o=0, m_cycle_o=0.
REQ-031 Reset assertion mid-instruction SHALL abort immediately; the first cycle after release SHALL be FETCH.

Structure
REQ-032 gb_cpu_common_pkg SHALL hold the sequencer state enum, FETCH_CTRL, and the NOP control constant.
REQ-033 Condition evaluation SHALL be a sub-module, gb_cpu_cond_eval (condition_code_t, alu_flags_t -> met).

Verification
REQ-034 Reset release -> cycle 0: FETCH_CTRL with boundary_o=1; cycle 1: sched_i entry 0 with m_cycle_o=0.
REQ-035 L=3 schedule, no stall -> m_cycle_o 0,1,2, with boundary_o only on 2, then the new schedule loads.
REQ-036 JR NZ (L=3, cc_check on entry 1, condition NZ) with Z=1 -> entries 0,1,2, total 3 cycles; with Z=0 the same sequence, no skip; with cc_check on entry 0 and a failed condition -> entries 0,2.
REQ-037 int_pending_i=1 at a boundary following cb_prefix_next=1 -> sched_i latched, no int_ack_o; at the next boundary -> int_sched_i latched and int_ack_o pulses once.
REQ-038 stall_i=1 for 2 cycles at m_cycle 1 of an L=4 schedule -> ctrl_o zero for 2 cycles, then entries 1,2,3 resume.
REQ-039 rst_n low during m_cycle 2 of an L=5 schedule -> outputs at reset values asynchronously; FETCH on the first cycle after release.
